mux_scan_ctrl: RTL and testbench

//  Upstream sequencer for the 4:1 gate-level mux. Drives its 2-bit select,

---
 rtl/mux_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
//==============================================================================
// Module      : mux_scan_ctrl
// Description : Sequencer for a 4:1 mux. Drives the select, holds each
//               channel for SETTLE_CYCLES, samples the mux output once per
//               channel, and delivers the 4-bit snapshot over valid/ready.
//               Supports single-shot and continuous scanning, a synchronous
//               abort, and a start-while-busy error pulse.
// Ports       : clk, rst_n (async, active low)
//               start, abort, continuous, ready : control inputs
//               mux_out                         : mux data under control
//               sel[1:0]                        : select driven to the mux
//               sample[3:0], valid              : snapshot and its qualifier
//               busy, start_err                 : status
//               frame_cnt[CNT_W-1:0]            : accepted snapshots (wraps)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             continuous,
    input  logic             mux_out,
    input  logic             ready,
    output logic [1:0]       sel,
    output logic [3:0]       sample,
    output logic             valid,
    output logic             busy,
    output logic             start_err,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    // Settle counter value on the last SETTLE cycle of a channel.
    localparam logic [7:0]       C_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_FRAME_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [7:0]       cnt_q;
    logic [3:0]       shadow_q;
    logic [1:0]       sel_q;
    logic [3:0]       sample_q;
    logic             valid_q;
    logic             busy_q;
    logic             start_err_q;
    logic [CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            shadow_q    <= 4'd0;
            sel_q       <= 2'd0;
            sample_q    <= 4'd0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            start_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            // A start seen outside IDLE is dropped but flagged for one cycle.
            start_err_q <= start && (state_q != S_IDLE);

            if (abort) begin
                // Abort wins over any handshake; sample keeps its last value.
                state_q <= S_IDLE;
                sel_q   <= 2'd0;
                cnt_q   <= 8'd0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        sel_q <= 2'd0;
                        if (start) begin
                            cnt_q    <= 8'd0;
                            shadow_q <= 4'd0;
                            busy_q   <= 1'b1;
                            state_q  <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == C_SETTLE_LAST) begin
                            state_q <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        shadow_q[sel_q] <= mux_out;
                        if (sel_q != 2'd3) begin
                            sel_q   <= sel_q + 2'd1;
                            cnt_q   <= 8'd0;
                            state_q <= S_SETTLE;
                        end else begin
                            // Channel 3 goes straight into the snapshot.
                            sample_q <= {mux_out, shadow_q[2:0]};
                            valid_q  <= 1'b1;
                            state_q  <= S_OUTPUT;
                        end
                    end
                    S_OUTPUT: begin
                        if (ready) begin
                            valid_q     <= 1'b0;
                            frame_cnt_q <= frame_cnt_q + C_FRAME_ONE;
                            sel_q       <= 2'd0;
                            cnt_q       <= 8'd0;
                            if (continuous) begin
                                state_q <= S_SETTLE;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        sel_q   <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign sel       = sel_q;
    assign sample    = sample_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign start_err = start_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
//==============================================================================
// Module      : tb_mux_scan_ctrl
// Description : Directed self-checking bench for mux_scan_ctrl. A second
//               instance with SETTLE_CYCLES=3 covers the longer settle time.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;

    // Instance with default settle time
    logic       start, abort, continuous, ready;
    logic [3:0] mux_in;
    logic       mux_out;
    logic [1:0] sel;
    logic [3:0] sample;
    logic       valid, busy, start_err;
    logic [7:0] frame_cnt;

    // Instance with SETTLE_CYCLES=3
    logic       start3, abort3, cont3, ready3;
    logic [3:0] mux_in3;
    logic       mux_out3;
    logic [1:0] sel3;
    logic [3:0] sample3;
    logic       valid3, busy3, start_err3;
    logic [7:0] frame_cnt3;

    int checks = 0;
    int errors = 0;
    logic [7:0] fexp;

    // Behavioural 4:1 mux under control
    assign mux_out  = mux_in[sel];
    assign mux_out3 = mux_in3[sel3];

    mux_scan_ctrl #(.SETTLE_CYCLES(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .continuous(continuous), .mux_out(mux_out), .ready(ready),
        .sel(sel), .sample(sample), .valid(valid), .busy(busy),
        .start_err(start_err), .frame_cnt(frame_cnt)
    );

    mux_scan_ctrl #(.SETTLE_CYCLES(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .continuous(cont3), .mux_out(mux_out3), .ready(ready3),
        .sel(sel3), .sample(sample3), .valid(valid3), .busy(busy3),
        .start_err(start_err3), .frame_cnt(frame_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({sel, sample, valid, busy, start_err, frame_cnt} !== 16'd0) begin
            errors++;
            $display("FAIL reset_init got sel=%0d sample=%b valid=%b busy=%b err=%b fcnt=%0d exp all 0",
                     sel, sample, valid, busy, start_err, frame_cnt);
        end
        checks++;
        if ({sel3, sample3, valid3, busy3, start_err3, frame_cnt3} !== 16'd0) begin
            errors++;
            $display("FAIL reset_init3 got nonzero outputs on SETTLE_CYCLES=3 instance");
        end
        #9 rst_n = 1'b1;
        tick();
    endtask

    // T2: single scan, sel stepping, latency 8, snapshot 1101
    task automatic test_single();
        logic [1:0] e;
        mux_in = 4'b1101; ready = 1'b1; continuous = 1'b0;
        start = 1'b1;
        tick();                       // E0 samples start
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || sel !== 2'd0) begin
            errors++;
            $display("FAIL t2_start got busy=%b sel=%0d exp busy=1 sel=0", busy, sel);
        end
        for (int k = 1; k < 8; k++) begin
            tick();
            e = 2'(k / 2);
            checks++;
            if (sel !== e || valid !== 1'b0) begin
                errors++;
                $display("FAIL t2_step edge=%0d got sel=%0d valid=%b exp sel=%0d valid=0", k, sel, valid, e);
            end
        end
        tick();                       // E8
        checks++;
        if (valid !== 1'b1 || sample !== 4'b1101) begin
            errors++;
            $display("FAIL t2_valid got valid=%b sample=%b exp valid=1 sample=1101", valid, sample);
        end
        tick();                       // E9 handshake
        fexp = fexp + 8'd1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || sel !== 2'd0 || frame_cnt !== fexp) begin
            errors++;
            $display("FAIL t2_done got valid=%b busy=%b sel=%0d fcnt=%0d exp 0 0 0 %0d",
                     valid, busy, sel, frame_cnt, fexp);
        end
    endtask

    // T1: asynchronous reset while SETTLE on channel 2
    task automatic test_reset_mid();
        mux_in = 4'b0101; ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (sel !== 2'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_pre got sel=%0d busy=%b exp sel=2 busy=1", sel, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sel, sample, valid, busy, start_err, frame_cnt} !== 16'd0) begin
            errors++;
            $display("FAIL t1_async got sel=%0d sample=%b valid=%b busy=%b err=%b fcnt=%0d exp all 0",
                     sel, sample, valid, busy, start_err, frame_cnt);
        end
        #2 rst_n = 1'b1;
        fexp = 8'd0;
        tick();
    endtask

    // T3: SETTLE_CYCLES=3, valid at +16, ready withheld 5 cycles
    task automatic test_settle3();
        mux_in3 = 4'b0110; ready3 = 1'b0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int k = 1; k < 16; k++) begin
            tick();
            checks++;
            if (valid3 !== 1'b0) begin
                errors++;
                $display("FAIL t3_early edge=%0d got valid=1 exp 0", k);
            end
        end
        for (int k = 16; k < 22; k++) begin
            tick();
            checks++;
            if (valid3 !== 1'b1 || sample3 !== 4'b0110 || frame_cnt3 !== 8'd0) begin
                errors++;
                $display("FAIL t3_hold edge=%0d got valid=%b sample=%b fcnt=%0d exp 1 0110 0",
                         k, valid3, sample3, frame_cnt3);
            end
        end
        ready3 = 1'b1;                // sixth valid cycle
        tick();
        ready3 = 1'b0;
        checks++;
        if (valid3 !== 1'b0 || frame_cnt3 !== 8'd1 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL t3_hs got valid=%b fcnt=%0d busy=%b exp 0 1 0", valid3, frame_cnt3, busy3);
        end
    endtask

    // T5: start pulse during channel-1 CAPTURE
    task automatic test_start_err();
        mux_in = 4'b1010; ready = 1'b1; continuous = 1'b0;
        start = 1'b1;
        tick();                       // E0
        start = 1'b0;
        for (int k = 1; k < 4; k++) tick();
        start = 1'b1;                 // CAPTURE of ch1
        tick();                       // E4
        start = 1'b0;
        checks++;
        if (start_err !== 1'b1 || sel !== 2'd2) begin
            errors++;
            $display("FAIL t5_err got start_err=%b sel=%0d exp 1 2", start_err, sel);
        end
        tick();                       // E5
        checks++;
        if (start_err !== 1'b0) begin
            errors++;
            $display("FAIL t5_pulse got start_err=%b exp 0", start_err);
        end
        tick(); tick(); tick();       // E8
        checks++;
        if (valid !== 1'b1 || sample !== 4'b1010) begin
            errors++;
            $display("FAIL t5_sample got valid=%b sample=%b exp 1 1010", valid, sample);
        end
        tick();
        fexp = fexp + 8'd1;
        checks++;
        if (frame_cnt !== fexp || busy !== 1'b0) begin
            errors++;
            $display("FAIL t5_done got fcnt=%0d busy=%b exp %0d 0", frame_cnt, busy, fexp);
        end
    endtask

    // T6: abort coinciding with handshake; then abort+start in IDLE
    task automatic test_abort();
        mux_in = 4'b0011; ready = 1'b0; continuous = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 9; k++) tick();
        checks++;
        if (valid !== 1'b1 || sample !== 4'b0011) begin
            errors++;
            $display("FAIL t6_pre got valid=%b sample=%b exp 1 0011", valid, sample);
        end
        mux_in = 4'b1100;
        ready = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0; ready = 1'b0; continuous = 1'b0;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || sel !== 2'd0 ||
            frame_cnt !== fexp || sample !== 4'b0011) begin
            errors++;
            $display("FAIL t6_abort got valid=%b busy=%b sel=%0d fcnt=%0d sample=%b exp 0 0 0 %0d 0011",
                     valid, busy, sel, frame_cnt, sample, fexp);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL t6_idle got busy=%b valid=%b exp 0 0", busy, valid);
        end
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || start_err !== 1'b0) begin
            errors++;
            $display("FAIL t6_start_abort got busy=%b start_err=%b exp 0 0", busy, start_err);
        end
    endtask

    // T4: continuous scanning, one snapshot per 9 cycles, frame_cnt wrap
    task automatic test_continuous();
        logic [3:0] pat;
        int cyc;
        int nframes;
        nframes = 256;
        pat = 4'd3;
        mux_in = pat; ready = 1'b1; continuous = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int f = 0; f < nframes; f++) begin
            cyc = 0;
            while (valid !== 1'b1 && cyc < 40) begin
                tick();
                cyc++;
            end
            checks++;
            if (cyc != 8) begin
                errors++;
                $display("FAIL t4_period frame=%0d got %0d cycles exp 8 (9 per frame)", f, cyc);
                if (cyc >= 40) begin
                    $display("CHECKS %0d ERRORS %0d", checks, errors);
                    $fatal(1, "FAIL t4_timeout no valid within bound");
                end
            end
            checks++;
            if (sample !== pat) begin
                errors++;
                $display("FAIL t4_sample frame=%0d got %b exp %b", f, sample, pat);
            end
            pat = pat + 4'd5;
            mux_in = pat;
            if (f == nframes - 1) continuous = 1'b0;
            tick();                   // handshake edge
            fexp = fexp + 8'd1;
            checks++;
            if (frame_cnt !== fexp || valid !== 1'b0) begin
                errors++;
                $display("FAIL t4_fcnt frame=%0d got fcnt=%0d valid=%b exp %0d 0", f, frame_cnt, valid, fexp);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL t4_stop got busy=%b exp 0", busy);
        end
    endtask

    initial begin
        start = 0; abort = 0; continuous = 0; ready = 0; mux_in = 4'd0;
        start3 = 0; abort3 = 0; cont3 = 0; ready3 = 0; mux_in3 = 4'd0;
        fexp = 8'd0;
        test_reset();
        test_single();
        test_reset_mid();
        test_settle3();
        test_start_err();
        test_abort();
        test_continuous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
